// File: rtl/template_arbiter.sv
// Round-robin, burst-granular arbiter sharing one template datapath between NUM_REQ requesters.
// Optional per-requester beat counters are enabled by defining TEMPLATE_ARBITER_STATS_EN.
module template_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MAX_BURST  = 8,
   parameter int unsigned TAG_DEPTH  = 8
) (
`ifdef TEMPLATE_ARBITER_STATS_EN
   output logic [NUM_REQ*16-1:0]         beat_count,
`endif
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         input_data,
   output logic                          enable,
   input  logic [DATA_WIDTH-1:0]         output_data,
   input  logic                          output_data_valid,
   output logic [DATA_WIDTH-1:0]         result_data,
   output logic                          result_valid,
   output logic [$clog2(NUM_REQ)-1:0]    result_id,
   output logic                          busy,
   output logic                          err_orphan
);

   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned PtrW = $clog2(TAG_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e           state_q, state_d;
   logic [IdW-1:0]   grant_q, grant_d;
   logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [7:0]       beat_cnt_q, beat_cnt_d;

   logic [IdW-1:0]   tag_mem [TAG_DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  tag_cnt_q;
   logic             tag_full, tag_empty;

   logic [DATA_WIDTH-1:0] input_data_q, result_data_q;
   logic                  enable_q, result_valid_q, err_orphan_q;
   logic [IdW-1:0]        result_id_q;

   logic             found;
   logic [IdW-1:0]   pick, arb_idx;
   logic             accept, pop, pop_eff, orphan;
   logic [IdW-1:0]   pop_tag;

   assign tag_full  = (tag_cnt_q == CntW'(TAG_DEPTH));
   assign tag_empty = (tag_cnt_q == '0);

   // First valid requester at or after rr_ptr, cyclically.
   always_comb begin
      found   = 1'b0;
      pick    = rr_ptr_q;
      arb_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         arb_idx = IdW'((32'(rr_ptr_q) + i) % NUM_REQ);
         if (!found && req_valid[arb_idx]) begin
            found = 1'b1;
            pick  = arb_idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      req_ready  = '0;
      accept     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               grant_d = pick;
               state_d = StBurst;
            end
         end
         StBurst: begin
            req_ready[grant_q] = !tag_full;
            accept             = req_valid[grant_q] && !tag_full;
            if (accept) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
               if (req_last[grant_q] || (beat_cnt_q + 8'd1 == 8'(MAX_BURST))) begin
                  state_d    = StIdle;
                  beat_cnt_d = '0;
                  rr_ptr_d   = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + IdW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // An empty FIFO with a same-cycle push hands the pushed tag straight through.
   assign pop     = output_data_valid;
   assign orphan  = pop && tag_empty && !accept;
   assign pop_eff = pop && !orphan;
   assign pop_tag = tag_empty ? grant_q : tag_mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (accept) tag_mem[wr_ptr_q] <= grant_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         grant_q        <= '0;
         rr_ptr_q       <= '0;
         beat_cnt_q     <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         tag_cnt_q      <= '0;
         input_data_q   <= '0;
         enable_q       <= 1'b0;
         result_data_q  <= '0;
         result_valid_q <= 1'b0;
         result_id_q    <= '0;
         err_orphan_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         enable_q   <= accept;
         if (accept) begin
            input_data_q <= req_data[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            wr_ptr_q     <= wr_ptr_q + PtrW'(1);
         end
         if (pop_eff) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (accept && !pop_eff)      tag_cnt_q <= tag_cnt_q + CntW'(1);
         else if (pop_eff && !accept) tag_cnt_q <= tag_cnt_q - CntW'(1);
         result_valid_q <= pop;
         if (pop) begin
            result_data_q <= output_data;
            result_id_q   <= orphan ? '0 : pop_tag;
         end
         if (orphan) err_orphan_q <= 1'b1;
      end
   end

   assign input_data   = input_data_q;
   assign enable       = enable_q;
   assign result_data  = result_data_q;
   assign result_valid = result_valid_q;
   assign result_id    = result_id_q;
   assign err_orphan   = err_orphan_q;
   assign busy         = (state_q != StIdle) || !tag_empty;

`ifdef TEMPLATE_ARBITER_STATS_EN
   logic [15:0] stat_q [NUM_REQ];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (reset) begin
            stat_q[i] <= '0;
         end else if (accept && (grant_q == IdW'(i)) && (stat_q[i] != 16'hFFFF)) begin
            stat_q[i] <= stat_q[i] + 16'd1;
         end
      end
   end

   always_comb begin
      beat_count = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) beat_count[i*16 +: 16] = stat_q[i];
   end
`endif

endmodule

// File: tb/tb_template_arbiter.sv
// Self-checking bench for template_arbiter: accepted beats feed an expected-result scoreboard,
// an identity datapath model (stallable, with orphan injection) returns results.
module tb_template_arbiter;
   localparam int NR = 4;
   localparam int DW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*DW-1:0]  req_data = '0;
   logic [NR-1:0]     req_last = '0;
   logic [NR-1:0]     req_ready;
   logic [DW-1:0]     input_data;
   logic              enable;
   logic [DW-1:0]     output_data = '0;
   logic              output_data_valid = 1'b0;
   logic [DW-1:0]     result_data;
   logic              result_valid;
   logic [1:0]        result_id;
   logic              busy;
   logic              err_orphan;
`ifdef TEMPLATE_ARBITER_STATS_EN
   logic [NR*16-1:0]  beat_count;
`endif

   template_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(8), .TAG_DEPTH(8)
   ) dut (
`ifdef TEMPLATE_ARBITER_STATS_EN
      .beat_count(beat_count),
`endif
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .input_data(input_data), .enable(enable),
      .output_data(output_data), .output_data_valid(output_data_valid),
      .result_data(result_data), .result_valid(result_valid), .result_id(result_id),
      .busy(busy), .err_orphan(err_orphan)
   );

   logic [16:0]   src_q [NR][$];   // {last, data} per requester
   logic [DW-1:0] dp_q[$];
   int exp_id_q[$], exp_data_q[$], exp_cyc_q[$];
   int res_id_q[$], res_data_q[$], res_cyc_q[$];
   int iss_data_q[$], iss_cyc_q[$];
   logic          stall = 1'b0;
   logic [DW-1:0] inj_data = '0;
   int inject_req = 0, inject_done = 0, flush_req = 0, flush_done = 0;
   logic [NR-1:0] cand;
   int cyc = 0;
   int n_checks = 0, n_fail = 0;

   always @(posedge clk) cyc++;

   // Requester sources, acceptance scoreboard push, and identity datapath.
   always @(posedge clk) begin
      #1;
      if (flush_req != flush_done) begin
         for (int i = 0; i < NR; i++) src_q[i].delete();
         dp_q.delete();
         flush_done = flush_req;
      end
      for (int i = 0; i < NR; i++) begin
         if (cand[i] && !reset) begin
            exp_id_q.push_back(i);
            exp_data_q.push_back(int'(req_data[i*DW +: DW]));
            exp_cyc_q.push_back(cyc);
            if (src_q[i].size() > 0) void'(src_q[i].pop_front());
         end
         if (src_q[i].size() > 0) begin
            req_valid[i]         = 1'b1;
            req_data[i*DW +: DW] = src_q[i][0][15:0];
            req_last[i]          = src_q[i][0][16];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
         end
      end
      if (enable) dp_q.push_back(input_data);
      if (inject_req != inject_done) begin
         output_data_valid = 1'b1;
         output_data       = inj_data;
         inject_done       = inject_req;
      end else if (!stall && dp_q.size() > 0) begin
         output_data_valid = 1'b1;
         output_data       = dp_q.pop_front();
      end else begin
         output_data_valid = 1'b0;
      end
   end

   always @(negedge clk) begin
      cand = req_valid & req_ready;
      if (enable) begin
         iss_data_q.push_back(int'(input_data));
         iss_cyc_q.push_back(cyc);
      end
      if (result_valid) begin
         res_id_q.push_back(int'(result_id));
         res_data_q.push_back(int'(result_data));
         res_cyc_q.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      exp_id_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
      res_id_q.delete(); res_data_q.delete(); res_cyc_q.delete();
      iss_data_q.delete(); iss_cyc_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      flush_req++;
      tick(1);
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic wait_exp(input int n, input int budget);
      while (exp_id_q.size() < n && budget > 0) begin
         tick(1);
         budget--;
      end
   endtask

   task automatic wait_res(input int n, input int budget);
      while (res_id_q.size() < n && budget > 0) begin
         tick(1);
         budget--;
      end
   endtask

   task automatic test_reset();
      tick(2);
      do_reset();
      n_checks++;
      if ({req_ready, enable, input_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_issue: got ready=%b en=%b in=%h, need all 0", req_ready, enable,
                  input_data);
      end
      n_checks++;
      if ({result_valid, result_id, result_data, busy, err_orphan} !== '0) begin
         n_fail++;
         $display("FAIL reset_result: got v=%b id=%0d d=%h busy=%b orph=%b, need all 0",
                  result_valid, result_id, result_data, busy, err_orphan);
      end
   endtask

   task automatic test_single();
      int exp_d[3] = '{'h11, 'h22, 'h33};
      int id, d, eid, ed;
      do_reset();
      for (int k = 0; k < 3; k++) src_q[0].push_back({k == 2, 16'(exp_d[k])});
      wait_res(3, 40);
      n_checks++;
      if (iss_data_q.size() != 3) begin
         n_fail++;
         $display("FAIL single_issue_count: got %0d, need 3", iss_data_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (iss_data_q[k] != exp_d[k]) begin
               n_fail++;
               $display("FAIL single_issue_data[%0d]: got %h, need %h", k, iss_data_q[k], exp_d[k]);
            end
         end
         n_checks++;
         if (iss_cyc_q[2] - iss_cyc_q[0] != 2) begin
            n_fail++;
            $display("FAIL single_enable_consecutive: span %0d, need 2", iss_cyc_q[2] - iss_cyc_q[0]);
         end
      end
      n_checks++;
      if (res_id_q.size() != 3) begin
         n_fail++;
         $display("FAIL single_result_count: got %0d, need 3", res_id_q.size());
      end
      while (res_id_q.size() > 0 && exp_id_q.size() > 0) begin
         id = res_id_q.pop_front(); d = res_data_q.pop_front();
         eid = exp_id_q.pop_front(); ed = exp_data_q.pop_front();
         n_checks++;
         if (id != 0 || d != ed || eid != 0) begin
            n_fail++;
            $display("FAIL single_result: got id=%0d d=%h, need id=0 d=%h", id, d, ed);
         end
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_busy_after: got %b, need 0", busy);
      end
   endtask

   task automatic test_round_robin();
      int id, d, eid, ed;
      do_reset();
      for (int r = 0; r < NR; r++)
         for (int k = 0; k < 4; k++) src_q[r].push_back({(k % 2) == 1, 16'(r * 256 + k)});
      wait_exp(16, 80);
      n_checks++;
      if (exp_id_q.size() != 16) begin
         n_fail++;
         $display("FAIL rr_accept_count: got %0d, need 16", exp_id_q.size());
      end else begin
         for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (exp_id_q[k] != (k / 2) % NR) begin
               n_fail++;
               $display("FAIL rr_grant_order[%0d]: got %0d, need %0d", k, exp_id_q[k], (k / 2) % NR);
            end
         end
         n_checks++;
         if (exp_cyc_q[1] - exp_cyc_q[0] != 1 || exp_cyc_q[2] - exp_cyc_q[1] != 2) begin
            n_fail++;
            $display("FAIL rr_bubble: gaps %0d,%0d, need 1,2", exp_cyc_q[1] - exp_cyc_q[0],
                     exp_cyc_q[2] - exp_cyc_q[1]);
         end
      end
      wait_res(16, 40);
      n_checks++;
      if (res_id_q.size() != 16) begin
         n_fail++;
         $display("FAIL rr_result_count: got %0d, need 16", res_id_q.size());
      end
      while (res_id_q.size() > 0 && exp_id_q.size() > 0) begin
         id = res_id_q.pop_front(); d = res_data_q.pop_front();
         eid = exp_id_q.pop_front(); ed = exp_data_q.pop_front();
         n_checks++;
         if (id != eid || d != ed) begin
            n_fail++;
            $display("FAIL rr_result: got id=%0d d=%h, need id=%0d d=%h", id, d, eid, ed);
         end
      end
   endtask

   task automatic test_max_burst();
      int runs[$];
      int len, bad, id, d, eid, ed;
      do_reset();
      for (int k = 0; k < 20; k++) src_q[1].push_back({1'b0, 16'('h1000 + k)});
      wait_exp(20, 100);
      len = 1;
      bad = 0;
      for (int k = 1; k < exp_cyc_q.size(); k++) begin
         if (exp_cyc_q[k] == exp_cyc_q[k-1] + 1) len++;
         else begin
            runs.push_back(len);
            len = 1;
         end
      end
      if (exp_cyc_q.size() > 0) runs.push_back(len);
      foreach (exp_id_q[k]) if (exp_id_q[k] != 1) bad++;
      n_checks++;
      if (runs.size() != 3) begin
         n_fail++;
         $display("FAIL burst_run_count: got %0d runs, need 3", runs.size());
      end else begin
         n_checks++;
         if (runs[0] != 8 || runs[1] != 8 || runs[2] != 4) begin
            n_fail++;
            $display("FAIL burst_run_len: got %0d,%0d,%0d, need 8,8,4", runs[0], runs[1], runs[2]);
         end
      end
      n_checks++;
      if (bad != 0 || exp_id_q.size() != 20) begin
         n_fail++;
         $display("FAIL burst_grant: got %0d beats, %0d not req1, need 20 and 0",
                  exp_id_q.size(), bad);
      end
      wait_res(20, 40);
      while (res_id_q.size() > 0 && exp_id_q.size() > 0) begin
         id = res_id_q.pop_front(); d = res_data_q.pop_front();
         eid = exp_id_q.pop_front(); ed = exp_data_q.pop_front();
         n_checks++;
         if (id != eid || d != ed) begin
            n_fail++;
            $display("FAIL burst_result: got id=%0d d=%h, need id=%0d d=%h", id, d, eid, ed);
         end
      end
   endtask

   task automatic test_tag_full();
      int id, d, eid, ed;
      do_reset();
      stall = 1'b1;
      for (int k = 0; k < 9; k++) src_q[0].push_back({k == 8, 16'('h4000 + k)});
      tick(30);
      n_checks++;
      if (exp_id_q.size() != 8) begin
         n_fail++;
         $display("FAIL full_accept_count: got %0d, need 8", exp_id_q.size());
      end
      n_checks++;
      if (req_ready[0] !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL full_ready: got ready=%b busy=%b, need ready=0 busy=1", req_ready[0], busy);
      end
      stall = 1'b0;
      wait_res(9, 40);
      n_checks++;
      if (exp_cyc_q.size() != 9 || res_cyc_q.size() == 0) begin
         n_fail++;
         $display("FAIL full_drain: got %0d accepts %0d results, need 9 and 9",
                  exp_cyc_q.size(), res_cyc_q.size());
      end else if (exp_cyc_q[8] <= res_cyc_q[0]) begin
         n_fail++;
         $display("FAIL full_ninth_timing: accepted cycle %0d, need after %0d",
                  exp_cyc_q[8], res_cyc_q[0]);
      end
      while (res_id_q.size() > 0 && exp_id_q.size() > 0) begin
         id = res_id_q.pop_front(); d = res_data_q.pop_front();
         eid = exp_id_q.pop_front(); ed = exp_data_q.pop_front();
         n_checks++;
         if (id != eid || d != ed) begin
            n_fail++;
            $display("FAIL full_result: got id=%0d d=%h, need id=%0d d=%h", id, d, eid, ed);
         end
      end
   endtask

   task automatic test_orphan();
      do_reset();
      inj_data = 16'hBEEF;
      inject_req++;
      wait_res(1, 10);
      n_checks++;
      if (res_id_q.size() != 1) begin
         n_fail++;
         $display("FAIL orphan_result_count: got %0d, need 1", res_id_q.size());
      end else if (res_id_q[0] != 0 || res_data_q[0] != 'hBEEF) begin
         n_fail++;
         $display("FAIL orphan_result: got id=%0d d=%h, need id=0 d=beef", res_id_q[0],
                  res_data_q[0]);
      end
      tick(5);
      n_checks++;
      if (err_orphan !== 1'b1 || result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL orphan_sticky: got err=%b v=%b, need err=1 v=0", err_orphan, result_valid);
      end
      do_reset();
      n_checks++;
      if (err_orphan !== 1'b0) begin
         n_fail++;
         $display("FAIL orphan_clear: got %b, need 0", err_orphan);
      end
   endtask

   task automatic test_reset_mid_burst();
      int id, d, eid, ed;
      do_reset();
      for (int k = 0; k < 2; k++) src_q[1].push_back({k == 1, 16'('h1100 + k)});
      wait_res(2, 30);
      while (res_id_q.size() > 0 && exp_id_q.size() > 0) begin
         id = res_id_q.pop_front(); d = res_data_q.pop_front();
         eid = exp_id_q.pop_front(); ed = exp_data_q.pop_front();
         n_checks++;
         if (id != eid || d != ed) begin
            n_fail++;
            $display("FAIL midrst_pre_result: got id=%0d d=%h, need id=%0d d=%h", id, d, eid, ed);
         end
      end
      stall = 1'b1;
      for (int k = 0; k < 5; k++) src_q[2].push_back({k == 4, 16'('h2000 + k)});
      wait_exp(3, 20);
      reset = 1'b1;
      flush_req++;
      tick(1);
      n_checks++;
      if ({req_ready, enable, input_data, result_valid, result_id, result_data} !== '0
          || busy !== 1'b0 || err_orphan !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got ready=%b en=%b in=%h v=%b busy=%b, need all 0",
                  req_ready, enable, input_data, result_valid, busy);
      end
      reset = 1'b0;
      clear_logs();
      stall = 1'b0;
      src_q[1].push_back({1'b1, 16'h3100});
      src_q[3].push_back({1'b1, 16'h3300});
      wait_exp(2, 20);
      n_checks++;
      if (exp_id_q.size() != 2) begin
         n_fail++;
         $display("FAIL midrst_regrant_count: got %0d, need 2", exp_id_q.size());
      end else if (exp_id_q[0] != 1 || exp_id_q[1] != 3) begin
         n_fail++;
         $display("FAIL midrst_regrant_order: got %0d,%0d, need 1,3", exp_id_q[0], exp_id_q[1]);
      end
      wait_res(2, 20);
      while (res_id_q.size() > 0 && exp_id_q.size() > 0) begin
         id = res_id_q.pop_front(); d = res_data_q.pop_front();
         eid = exp_id_q.pop_front(); ed = exp_data_q.pop_front();
         n_checks++;
         if (id != eid || d != ed) begin
            n_fail++;
            $display("FAIL midrst_result: got id=%0d d=%h, need id=%0d d=%h", id, d, eid, ed);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_max_burst();
      test_tag_full();
      test_orphan();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
